// File: rtl/latealu_pkg.sv
// rtl/latealu_pkg.sv - opcodes, sequencer states and shared helpers for the LateALU HI/LO unit
package latealu_pkg;

  localparam logic [5:0] OP_MULT  = 6'b000100;
  localparam logic [5:0] OP_MTHI  = 6'b000101;
  localparam logic [5:0] OP_MTLO  = 6'b000110;
  localparam logic [5:0] OP_MULTU = 6'b000111;
  localparam logic [5:0] OP_DIV   = 6'b001000;
  localparam logic [5:0] OP_DIVU  = 6'b001001;

  localparam int unsigned MUL_LATENCY_MAX = 8;
  localparam int unsigned MUL_CNT_W       = $clog2(MUL_LATENCY_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DIV   = 2'd2,
    ST_FIXUP = 2'd3
  } state_e;

  function automatic logic [63:0] ext64(input logic [31:0] v, input logic sgn);
    return sgn ? {{32{v[31]}}, v} : {32'd0, v};
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/latealu_divider.sv
// rtl/latealu_divider.sv - unsigned radix-2 restoring divider core, one step per enabled cycle
module latealu_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        step_en,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] shifted;
  logic [32:0] diff;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[31]};
    // bit 32 of diff is the borrow: set when the divisor does not fit
    diff    = shifted - {1'b0, dvs_q};
    if (abort) begin
      quo_d = '0;
      rem_d = '0;
      dvs_d = '0;
    end else if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (step_en) begin
      if (!diff[32]) begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/latealu_ctrl.sv
// rtl/latealu_ctrl.sv - LateALU sequencer: owns HI/LO, runs mult/div, stalls mfhi/mflo while busy
module latealu_ctrl
  import latealu_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned DIV_STEPS   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [5:0]  op,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic        flush,
  input  logic        hilo_read,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic        bad_op
);

  localparam int unsigned DIV_CNT_W = $clog2(DIV_STEPS + 1);

  state_e                state_q, state_d;
  logic [31:0]           hi_q, hi_d;
  logic [31:0]           lo_q, lo_d;
  logic                  done_q, done_d;
  logic                  bad_op_q, bad_op_d;
  logic [63:0]           prod_q, prod_d;
  logic [MUL_CNT_W-1:0]  mul_cnt_q, mul_cnt_d;
  logic [DIV_CNT_W-1:0]  div_cnt_q, div_cnt_d;
  logic [31:0]           dvd_q, dvd_d;
  logic [31:0]           dvs_q, dvs_d;
  logic                  quo_neg_q, quo_neg_d;
  logic                  rem_neg_q, rem_neg_d;

  logic                  div_start;
  logic                  div_step;
  logic [31:0]           div_quo;
  logic [31:0]           div_rem;
  logic                  is_signed;

  latealu_divider u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .step_en   (div_step),
    .abort     (flush),
    .dividend  (dvd_q),
    .divisor   (dvs_q),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign is_signed = (op == OP_MULT) || (op == OP_DIV);

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    bad_op_d  = 1'b0;
    prod_d    = prod_q;
    mul_cnt_d = mul_cnt_q;
    div_cnt_d = div_cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    div_start = 1'b0;
    div_step  = 1'b0;

    // flush wins over acceptance and over any completion write
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            case (op)
              OP_MTHI: begin
                hi_d   = a0;
                done_d = 1'b1;
              end
              OP_MTLO: begin
                lo_d   = a0;
                done_d = 1'b1;
              end
              OP_MULT, OP_MULTU: begin
                prod_d    = ext64(a0, is_signed) * ext64(a1, is_signed);
                mul_cnt_d = MUL_CNT_W'(MUL_LATENCY - 1);
                state_d   = ST_MUL;
              end
              OP_DIV, OP_DIVU: begin
                if (a1 == 32'd0) begin
                  lo_d   = 32'hFFFF_FFFF;
                  hi_d   = a0;
                  done_d = 1'b1;
                end else begin
                  dvd_d     = abs32(a0, is_signed);
                  dvs_d     = abs32(a1, is_signed);
                  quo_neg_d = is_signed && (a0[31] ^ a1[31]);
                  rem_neg_d = is_signed && a0[31];
                  div_cnt_d = '0;
                  state_d   = ST_DIV;
                end
              end
              default: bad_op_d = 1'b1;
            endcase
          end
        end
        ST_MUL: begin
          if (mul_cnt_q == '0) begin
            hi_d    = prod_q[63:32];
            lo_d    = prod_q[31:0];
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            mul_cnt_d = mul_cnt_q - 1'b1;
          end
        end
        ST_DIV: begin
          // first DIV cycle loads the core, the next DIV_STEPS cycles iterate
          if (div_cnt_q == '0) begin
            div_start = 1'b1;
          end else begin
            div_step = 1'b1;
          end
          div_cnt_d = div_cnt_q + 1'b1;
          if (div_cnt_q == DIV_CNT_W'(DIV_STEPS)) begin
            state_d = ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          lo_d    = quo_neg_q ? (~div_quo + 32'd1) : div_quo;
          hi_d    = rem_neg_q ? (~div_rem + 32'd1) : div_rem;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      bad_op_q  <= 1'b0;
      prod_q    <= '0;
      mul_cnt_q <= '0;
      div_cnt_q <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      bad_op_q  <= bad_op_d;
      prod_q    <= prod_d;
      mul_cnt_q <= mul_cnt_d;
      div_cnt_q <= div_cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end

  assign op_ready = (state_q == ST_IDLE);
  assign stall    = hilo_read && (state_q != ST_IDLE);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign done     = done_q;
  assign bad_op   = bad_op_q;

endmodule
